// File: rtl/mux_tree_pipe.sv
// Pipelined 2^SW-to-1 multiplexer built from registered 4-to-1 stages.
// The valid bit and the select that produced each entry travel with it; a scan counter can drive the select.
module mux_tree_pipe #(
  parameter int DW = 8,
  parameter int SW = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [(1<<SW)*DW-1:0]   W,
  input  logic [SW-1:0]           S,
  input  logic                    En,
  input  logic                    Mode,
  output logic [DW-1:0]           f,
  output logic                    Valid,
  output logic [SW-1:0]           Sel_out
);

  localparam int LEVELS = SW / 2;

  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_sel;

  assign w_sel = Mode ? r_cnt : S;

  // The current accept uses the pre-increment count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
    end else if (En && Mode) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar j = 1; j <= LEVELS; j++) begin : g_stage
    localparam int CNT = 1 << (SW - 2*j);
    localparam int LSB = 2*j - 2;

    logic [4*CNT*DW-1:0] w_src_dat;
    logic [SW-1:0]       w_src_sel;
    logic                w_src_vld;
    logic [CNT*DW-1:0]   w_nxt;
    logic [CNT*DW-1:0]   r_dat;
    logic [SW-1:0]       r_sel;
    logic                r_vld;

    if (j == 1) begin : g_in
      assign w_src_dat = W;
      assign w_src_sel = w_sel;
      assign w_src_vld = En;
    end else begin : g_chain
      assign w_src_dat = g_stage[j-1].r_dat;
      assign w_src_sel = g_stage[j-1].r_sel;
      assign w_src_vld = g_stage[j-1].r_vld;
    end

    always_comb begin
      w_nxt = '0;
      for (int g = 0; g < CNT; g++) begin
        w_nxt[g*DW +: DW] = w_src_dat[(4*g + int'(w_src_sel[LSB +: 2]))*DW +: DW];
      end
    end

    // Data and select hold while no entry arrives, so f/Sel_out keep their last delivery.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        r_dat <= '0;
        r_sel <= '0;
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_src_vld;
        if (w_src_vld) begin
          r_dat <= w_nxt;
          r_sel <= w_src_sel;
        end
      end
    end
  end

  assign f       = g_stage[LEVELS].r_dat;
  assign Sel_out = g_stage[LEVELS].r_sel;
  assign Valid   = g_stage[LEVELS].r_vld;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: directed tables, hand sequences and a random
// stream compared against a queue-based delivery model.
module tb_mux_tree_pipe;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int N = 1 << SW;
  localparam int LEVELS = SW / 2;

  logic            Clock = 1'b0;
  logic            Resetn = 1'b0;
  logic [N*DW-1:0] W = '0;
  logic [SW-1:0]   S = '0;
  logic            En = 1'b0;
  logic            Mode = 1'b0;
  logic [DW-1:0]   f;
  logic            Valid;
  logic [SW-1:0]   Sel_out;

  mux_tree_pipe #(.DW(DW), .SW(SW)) dut (
    .Clock(Clock), .Resetn(Resetn), .W(W), .S(S), .En(En), .Mode(Mode),
    .f(f), .Valid(Valid), .Sel_out(Sel_out)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } ent_t;

  ent_t          q[$];
  int            ecnt = 0;
  int            m_cnt = 0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_f = '0;
  logic [SW-1:0] m_sel = '0;

  typedef struct {
    logic          en;
    logic [SW-1:0] s;
    logic          ev;
    logic [DW-1:0] ef;
    logic [SW-1:0] es;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] def_w();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 8'h10 + k[7:0];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_w();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_vld = 1'b0;
    m_f = '0;
    m_sel = '0;
  endtask

  // Entry accepted at edge e is delivered right after edge e+LEVELS-1.
  task automatic model_edge();
    logic [SW-1:0] sel;
    ent_t e;
    if (!Resetn) begin
      model_reset();
    end else begin
      if (En) begin
        sel = Mode ? SW'(m_cnt) : S;
        q.push_back('{ecnt + LEVELS - 1, W[int'(sel)*DW +: DW], sel});
        if (Mode) m_cnt = (m_cnt + 1) % N;
      end
      m_vld = 1'b0;
      if (q.size() > 0 && q[0].due == ecnt) begin
        e = q.pop_front();
        m_vld = 1'b1;
        m_f = e.d;
        m_sel = e.s;
      end
    end
    ecnt++;
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    chk("model_valid", {31'd0, Valid}, {31'd0, m_vld});
    chk("model_f", {24'd0, f}, {24'd0, m_f});
    chk("model_sel", {28'd0, Sel_out}, {28'd0, m_sel});
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    En = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {31'd0, Valid}, 32'd0);
    chk("rst_f", {24'd0, f}, 32'd0);
    chk("rst_sel", {28'd0, Sel_out}, 32'd0);
    #2;
    Resetn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd5, 1'b0, 8'h1F, 4'd15};
    tbl[1] = '{1'b0, 4'd0, 1'b1, 8'h15, 4'd5};
    tbl[2] = '{1'b0, 4'd0, 1'b0, 8'h15, 4'd5};
    tbl[3] = '{1'b0, 4'd0, 1'b0, 8'h15, 4'd5};
    tbl[4] = '{1'b1, 4'd9, 1'b0, 8'h15, 4'd5};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 8'h19, 4'd9};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 8'h19, 4'd9};

    // Reset held with live data on W and En asserted.
    W = def_w();
    En = 1'b1;
    S = 4'd3;
    repeat (3) step();
    En = 1'b0;
    @(negedge Clock);
    chk("hold_rst_f", {24'd0, f}, 32'd0);
    Resetn = 1'b1;
    repeat (3) step();

    // Direct sweep S=0..15.
    Mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      En = 1'b1;
      S = SW'(i);
      step();
    end
    En = 1'b0;
    repeat (2) step();

    // Gapped stream with hold.
    for (int i = 0; i < 7; i++) begin
      En = tbl[i].en;
      S = tbl[i].s;
      step();
      chk("tbl_valid", {31'd0, Valid}, {31'd0, tbl[i].ev});
      chk("tbl_f", {24'd0, f}, {24'd0, tbl[i].ef});
      chk("tbl_sel", {28'd0, Sel_out}, {28'd0, tbl[i].es});
    end

    // Scan with wrap from reset, then resume after an En gap.
    pulse_reset();
    Mode = 1'b1;
    En = 1'b1;
    repeat (18) step();
    En = 1'b0;
    repeat (2) step();
    En = 1'b1;
    step();
    En = 1'b0;
    step();
    chk("scan_resume_f", {24'd0, f}, 32'h12);
    chk("scan_resume_sel", {28'd0, Sel_out}, 32'd2);

    // Mode switch with W disturbed between accepts.
    pulse_reset();
    W = def_w();
    Mode = 1'b1;
    En = 1'b1;
    repeat (3) step();
    Mode = 1'b0;
    S = 4'd12;
    step();
    En = 1'b0;
    W = rand_w();
    step();
    chk("switch_direct_f", {24'd0, f}, 32'h1C);
    chk("switch_direct_sel", {28'd0, Sel_out}, 32'd12);
    W = def_w();
    Mode = 1'b1;
    En = 1'b1;
    step();
    En = 1'b0;
    W = rand_w();
    step();
    chk("switch_scan_f", {24'd0, f}, 32'h13);
    chk("switch_scan_sel", {28'd0, Sel_out}, 32'd3);
    step();

    // Async reset with entries in flight and a non-zero scan count.
    W = def_w();
    Mode = 1'b1;
    En = 1'b1;
    repeat (5) step();
    Mode = 1'b0;
    S = 4'd3;
    step();
    S = 4'd7;
    step();
    chk("pre_rst_f", {24'd0, f}, 32'h13);
    pulse_reset();
    S = 4'd8;
    repeat (4) step();
    chk("post_rst_no_valid", {31'd0, Valid}, 32'd0);
    Mode = 1'b1;
    En = 1'b1;
    step();
    En = 1'b0;
    step();
    chk("cnt_restart_f", {24'd0, f}, 32'h10);
    chk("cnt_restart_sel", {28'd0, Sel_out}, 32'd0);

    // Random stream against the model.
    for (int i = 0; i < 200; i++) begin
      W = rand_w();
      S = SW'($urandom);
      En = ($urandom_range(0, 3) != 0);
      Mode = $urandom_range(0, 1) == 1;
      step();
    end
    En = 1'b0;
    repeat (LEVELS + 1) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
